// File: rtl/ahb_lite_sram_responder.sv
// ahb_lite_sram_responder: AHB-Lite subordinate in front of a word-organised SRAM with wait states and ERROR responses
module ahb_lite_sram_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [2:0]    size_q, size_d;
    logic          hreadyout_q, hreadyout_d;
    logic          hresp_q, hresp_d;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          accept;
    logic          legal;
    logic [3:0]    lanes;
    logic [AW-1:0] idx;
    logic          unused;

    // Bursts are treated beat by beat, so HBURST and the SEQ/NONSEQ distinction carry no information here
    assign unused = ^{HBURST, HTRANS[0]};

    assign accept = HSEL & HREADY & HTRANS[1];
    assign legal  = HSIZE <= 3'd2
                 && (HSIZE == 3'd0 || (HSIZE == 3'd1 ? !HADDR[0] : HADDR[1:0] == 2'b00))
                 && 32'(HADDR) < LIMIT;
    assign idx    = addr_q[AW+1:2];
    assign lanes  = size_q == 3'd0 ? 4'b0001 << addr_q[1:0]
                  : size_q == 3'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011)
                  : 4'b1111;

    // Read data is driven straight from the array so a write closing on the previous edge is already visible
    assign HRDATA    = state_q == S_DONE && !write_q ? mem[idx] : '0;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

    // Next-state logic; IDLE, DONE and ERR2 are all points where a new address phase may be taken
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            S_WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q <= 4'd1 ? S_DONE : S_WAIT;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    addr_d  = HADDR[AW+1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = !legal ? S_ERR1 : (WAIT_STATES > 0 ? S_WAIT : S_DONE);
                end
            end
        endcase
        hreadyout_d = state_d != S_WAIT && state_d != S_ERR1;
        hresp_d     = state_d == S_ERR1 || state_d == S_ERR2;
    end

    // State and registered response outputs
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Byte-lane write at the closing edge of a write DONE cycle; reset forces IDLE so no partial write escapes
    always_ff @(posedge HCLK) begin
        if (state_q == S_DONE && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) mem[idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end
endmodule
